// File: rtl/lh_msg_feeder.sv
`default_nettype none
// ============================================================================
// Module      : lh_msg_feeder
// Description : Byte FIFO plus framing FSM that feeds light_hash one message
//               at a time as START_CHAR, data bytes, END_CHAR.
// Revision    : 1.0 - initial release
// ============================================================================
module lh_msg_feeder #(
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] START_CHAR = 8'hFF,
    parameter logic [7:0] END_CHAR   = 8'h00,
    parameter int         GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_char,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    input  logic       hash_busy,
    input  logic       digest_ready,
    output logic [7:0] ptxt_char,
    output logic       ptxt_valid,
    output logic       drop_pulse,
    output logic       msg_done,
    output logic       busy
);

    localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam int c_GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam logic [c_ADDR_W:0]  c_FULL_CNT = (c_ADDR_W + 1)'(FIFO_DEPTH);
    localparam logic [c_GAP_W-1:0] c_GAP_MIN  = c_GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_GAP      = 3'd2,
        S_DATA     = 3'd3,
        S_END      = 3'd4,
        S_WAIT_DIG = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Byte FIFO, entries are {last, char}
    // ------------------------------------------------------------------
    logic [8:0]          r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_count;

    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;
    logic [8:0] w_head;
    logic [7:0] w_head_char;
    logic       w_head_last;
    logic       w_head_reserved;

    assign w_full          = (r_count == c_FULL_CNT);
    assign w_empty         = (r_count == '0);
    assign in_ready        = !w_full && !rst;
    assign w_push          = in_valid && in_ready;
    assign w_head          = r_mem[r_rd_ptr];
    assign w_head_char     = w_head[7:0];
    assign w_head_last     = w_head[8];
    assign w_head_reserved = (w_head_char == START_CHAR) || (w_head_char == END_CHAR);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_last, in_char};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Framing FSM
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nxt;
    state_t             r_gap_next;     // where GAP goes once pacing allows
    state_t             w_gap_next_nxt;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic [7:0]         r_char_hold;
    logic               r_msg_done;

    logic       w_gap_done;
    logic       w_valid;
    logic [7:0] w_char;
    logic       w_drop;

    assign w_gap_done = (r_gap_cnt >= c_GAP_MIN);

    always_comb begin
        w_state_nxt    = r_state;
        w_gap_next_nxt = r_gap_next;
        w_valid        = 1'b0;
        w_char         = r_char_hold;
        w_drop         = 1'b0;
        w_pop          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_valid        = 1'b1;
                w_char         = START_CHAR;
                w_state_nxt    = S_GAP;
                w_gap_next_nxt = S_DATA;
            end
            S_GAP: begin
                if (w_gap_done && !hash_busy) begin
                    w_state_nxt = r_gap_next;
                end
            end
            S_DATA: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head_reserved) begin
                        // Framing bytes inside the payload would corrupt the frame
                        w_drop = 1'b1;
                        if (w_head_last) begin
                            w_state_nxt = S_END;
                        end
                    end else begin
                        w_valid        = 1'b1;
                        w_char         = w_head_char;
                        w_state_nxt    = S_GAP;
                        w_gap_next_nxt = w_head_last ? S_END : S_DATA;
                    end
                end
            end
            S_END: begin
                w_valid        = 1'b1;
                w_char         = END_CHAR;
                w_state_nxt    = S_GAP;
                w_gap_next_nxt = S_WAIT_DIG;
            end
            S_WAIT_DIG: begin
                if (digest_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_gap_next  <= S_DATA;
            r_gap_cnt   <= '0;
            r_char_hold <= 8'h00;
            r_msg_done  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gap_next <= w_gap_next_nxt;
            r_msg_done <= (r_state == S_WAIT_DIG) && digest_ready;
            if (w_valid) begin
                r_char_hold <= w_char;
            end
            if (r_state != S_GAP) begin
                r_gap_cnt <= '0;
            end else if (!w_gap_done) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end
        end
    end

    assign ptxt_valid = w_valid;
    assign ptxt_char  = w_char;
    assign drop_pulse = w_drop;
    assign msg_done   = r_msg_done;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_lh_msg_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_lh_msg_feeder
// Description : Directed self-checking bench for lh_msg_feeder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lh_msg_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_char = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic       digest_ready = 1'b0;
    logic [7:0] ptxt_char;
    logic       ptxt_valid;
    logic       drop_pulse;
    logic       msg_done;
    logic       busy;

    logic       man_busy = 1'b0;
    logic       auto_busy = 1'b0;
    logic       busy_mode = 1'b0;
    wire logic  hash_busy;
    assign hash_busy = busy_mode ? auto_busy : man_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_strobe = 0;
    int n_drop   = 0;
    int n_done   = 0;
    int done_cyc = -1;
    logic [7:0] log_char [0:255];
    int         log_cyc  [0:255];

    lh_msg_feeder #(
        .FIFO_DEPTH (16),
        .START_CHAR (8'hFF),
        .END_CHAR   (8'h00),
        .GAP_CYCLES (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_char      (in_char),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .hash_busy    (hash_busy),
        .digest_ready (digest_ready),
        .ptxt_char    (ptxt_char),
        .ptxt_valid   (ptxt_valid),
        .drop_pulse   (drop_pulse),
        .msg_done     (msg_done),
        .busy         (busy)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Strobe / pulse logger, sampled mid-cycle
    initial forever begin
        @(negedge clk);
        if (ptxt_valid && n_strobe < 256) begin
            log_char[n_strobe] = ptxt_char;
            log_cyc[n_strobe]  = cyc;
            n_strobe++;
        end
        if (drop_pulse) n_drop++;
        if (msg_done) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    // Hasher model: busy for 5 cycles after every strobe
    initial begin
        int busy_left;
        busy_left = 0;
        forever begin
            @(negedge clk);
            if (busy_mode && ptxt_valid) busy_left = 5;
            @(posedge clk);
            #1;
            auto_busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] c, input logic last, output int acc, output bit to);
        in_char  = c;
        in_last  = last;
        in_valid = 1'b1;
        to  = 1'b1;
        acc = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = cyc;
                to  = 1'b0;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_strobes(input int target, input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (n_strobe >= target) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic finish_msg(output bit to);
        int d0;
        d0 = n_done;
        digest_ready = 1'b1;
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (n_done > d0) begin
                to = 1'b0;
                break;
            end
        end
        digest_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_cycles(3);
        n_checks++; if (ptxt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", ptxt_valid); end
        n_checks++; if (ptxt_char !== 8'h00) begin n_fail++; $display("FAIL reset_char: got %h required 00", ptxt_char); end
        n_checks++; if (drop_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b required 0", drop_pulse); end
        n_checks++; if (msg_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", msg_done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b required 0", in_ready); end
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b required 1", in_ready); end
        wait_cycles(2);
    endtask

    task automatic test_basic();
        logic [7:0] ex [5];
        int s, a0, a, d0, dc;
        bit to, pto;
        ex = '{8'hFF, 8'h61, 8'h62, 8'h63, 8'h00};
        s = n_strobe;
        d0 = n_done;
        push(8'h61, 1'b0, a0, pto);
        push(8'h62, 1'b0, a, to); pto |= to;
        push(8'h63, 1'b1, a, to); pto |= to;
        wait_strobes(s + 5, 100, to);
        n_checks++; if ((to | pto) !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %0d strobes required %0d", n_strobe - s, 5); end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (log_char[s+i] !== ex[i]) begin n_fail++; $display("FAIL basic_char%0d: got %h required %h", i, log_char[s+i], ex[i]); end
        end
        n_checks++; if (log_cyc[s] !== a0 + 2) begin n_fail++; $display("FAIL basic_start_latency: got cycle %0d required %0d", log_cyc[s], a0 + 2); end
        for (int i = 1; i < 5; i++) begin
            n_checks++; if (log_cyc[s+i] - log_cyc[s+i-1] !== 2) begin n_fail++; $display("FAIL basic_spacing%0d: got %0d required 2", i, log_cyc[s+i] - log_cyc[s+i-1]); end
        end
        wait_cycles(3);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_wait_busy: got %b required 1", busy); end
        n_checks++; if (n_done !== d0) begin n_fail++; $display("FAIL basic_early_done: got %0d required %0d", n_done, d0); end
        digest_ready = 1'b1;
        dc = cyc;
        wait_cycles(1);
        digest_ready = 1'b0;
        wait_cycles(2);
        n_checks++; if (n_done !== d0 + 1) begin n_fail++; $display("FAIL basic_done_count: got %0d required %0d", n_done, d0 + 1); end
        n_checks++; if (done_cyc !== dc + 1) begin n_fail++; $display("FAIL basic_done_latency: got cycle %0d required %0d", done_cyc, dc + 1); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got %b required 0", busy); end
    endtask

    task automatic test_busy_pacing();
        logic [7:0] ex [5];
        int s, a;
        bit to, pto;
        ex = '{8'hFF, 8'h61, 8'h62, 8'h63, 8'h00};
        busy_mode = 1'b1;
        s = n_strobe;
        pto = 1'b0;
        push(8'h61, 1'b0, a, to); pto |= to;
        push(8'h62, 1'b0, a, to); pto |= to;
        push(8'h63, 1'b1, a, to); pto |= to;
        wait_strobes(s + 5, 300, to);
        n_checks++; if ((to | pto) !== 1'b0) begin n_fail++; $display("FAIL pace_timeout: got %0d strobes required 5", n_strobe - s); end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (log_char[s+i] !== ex[i]) begin n_fail++; $display("FAIL pace_char%0d: got %h required %h", i, log_char[s+i], ex[i]); end
        end
        for (int i = 1; i < 5; i++) begin
            n_checks++; if (log_cyc[s+i] - log_cyc[s+i-1] !== 7) begin n_fail++; $display("FAIL pace_spacing%0d: got %0d required 7", i, log_cyc[s+i] - log_cyc[s+i-1]); end
        end
        finish_msg(to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL pace_done: got timeout required msg_done"); end
        busy_mode = 1'b0;
        wait_cycles(2);
    endtask

    task automatic test_fifo_full();
        int s, a;
        bit to, pto;
        logic [7:0] e;
        man_busy = 1'b1;
        s = n_strobe;
        pto = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push(8'h10 + 8'(i), 1'b0, a, to);
            pto |= to;
        end
        n_checks++; if (pto !== 1'b0) begin n_fail++; $display("FAIL full_push_timeout: got timeout required 16 accepted"); end
        in_char  = 8'h20;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready%0d: got %b required 0", k, in_ready); end
        end
        n_checks++; if (n_strobe !== s + 1) begin n_fail++; $display("FAIL full_stalled: got %0d strobes required 1", n_strobe - s); end
        @(posedge clk);
        #1;
        man_busy = 1'b0;
        a = -1;
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                a  = cyc;
                to = 1'b0;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL full_17_timeout: got timeout required accept"); end
        n_checks++; if (a !== log_cyc[s+1] + 1) begin n_fail++; $display("FAIL full_17_accept: got cycle %0d required %0d", a, log_cyc[s+1] + 1); end
        wait_strobes(s + 19, 300, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL full_stream_timeout: got %0d strobes required 19", n_strobe - s); end
        n_checks++; if (log_char[s] !== 8'hFF) begin n_fail++; $display("FAIL full_start: got %h required ff", log_char[s]); end
        for (int i = 0; i < 17; i++) begin
            e = 8'h10 + 8'(i);
            n_checks++; if (log_char[s+1+i] !== e) begin n_fail++; $display("FAIL full_byte%0d: got %h required %h", i, log_char[s+1+i], e); end
        end
        n_checks++; if (log_char[s+18] !== 8'h00) begin n_fail++; $display("FAIL full_end: got %h required 00", log_char[s+18]); end
        finish_msg(to);
        wait_cycles(3);
        n_checks++; if ((to !== 1'b0) || (n_strobe !== s + 19)) begin n_fail++; $display("FAIL full_total: got %0d strobes to=%b required 19 to=0", n_strobe - s, to); end
    endtask

    task automatic test_drop();
        logic [7:0] ex [4];
        int s, d0, a;
        bit to, pto;
        ex = '{8'hFF, 8'h61, 8'h62, 8'h00};
        s = n_strobe;
        d0 = n_drop;
        pto = 1'b0;
        push(8'h61, 1'b0, a, to); pto |= to;
        push(8'hFF, 1'b0, a, to); pto |= to;
        push(8'h62, 1'b1, a, to); pto |= to;
        wait_strobes(s + 4, 100, to);
        finish_msg(to);
        wait_cycles(3);
        n_checks++; if ((to | pto) !== 1'b0) begin n_fail++; $display("FAIL drop_timeout: got timeout required completion"); end
        n_checks++; if (n_strobe !== s + 4) begin n_fail++; $display("FAIL drop_count_strobes: got %0d required 4", n_strobe - s); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (log_char[s+i] !== ex[i]) begin n_fail++; $display("FAIL drop_char%0d: got %h required %h", i, log_char[s+i], ex[i]); end
        end
        n_checks++; if (n_drop !== d0 + 1) begin n_fail++; $display("FAIL drop_pulses: got %0d required 1", n_drop - d0); end
        s = n_strobe;
        d0 = n_drop;
        push(8'hFF, 1'b1, a, pto);
        wait_strobes(s + 2, 100, to);
        finish_msg(to);
        wait_cycles(3);
        n_checks++; if (pto !== 1'b0) begin n_fail++; $display("FAIL empty_push: got timeout required accept"); end
        n_checks++; if (n_strobe !== s + 2) begin n_fail++; $display("FAIL empty_count_strobes: got %0d required 2", n_strobe - s); end
        n_checks++; if (log_char[s] !== 8'hFF) begin n_fail++; $display("FAIL empty_start: got %h required ff", log_char[s]); end
        n_checks++; if (log_char[s+1] !== 8'h00) begin n_fail++; $display("FAIL empty_end: got %h required 00", log_char[s+1]); end
        n_checks++; if (n_drop !== d0 + 1) begin n_fail++; $display("FAIL empty_drop: got %0d required 1", n_drop - d0); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] ex [3];
        int s, a;
        bit to, pto;
        s = n_strobe;
        pto = 1'b0;
        push(8'h61, 1'b0, a, to); pto |= to;
        push(8'h62, 1'b0, a, to); pto |= to;
        push(8'h63, 1'b0, a, to); pto |= to;
        push(8'h64, 1'b1, a, to); pto |= to;
        wait_strobes(s + 3, 100, to);
        n_checks++; if ((to | pto) !== 1'b0 || log_char[s+2] !== 8'h62) begin n_fail++; $display("FAIL rstmid_pre: got %h required 62", log_char[s+2]); end
        rst = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready: got %b required 0", in_ready); end
        wait_cycles(1);
        n_checks++; if ({ptxt_valid, drop_pulse, msg_done, busy} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_outputs: got %b required 0000", {ptxt_valid, drop_pulse, msg_done, busy}); end
        n_checks++; if (ptxt_char !== 8'h00) begin n_fail++; $display("FAIL rstmid_char: got %h required 00", ptxt_char); end
        rst = 1'b0;
        wait_cycles(4);
        n_checks++; if (n_strobe !== s + 3) begin n_fail++; $display("FAIL rstmid_flushed: got %0d strobes required 3", n_strobe - s); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got %b required 0", busy); end
        ex = '{8'hFF, 8'h7A, 8'h00};
        s = n_strobe;
        push(8'h7A, 1'b1, a, pto);
        wait_strobes(s + 3, 100, to);
        n_checks++; if ((to | pto) !== 1'b0) begin n_fail++; $display("FAIL rstmid_z_timeout: got %0d strobes required 3", n_strobe - s); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (log_char[s+i] !== ex[i]) begin n_fail++; $display("FAIL rstmid_z%0d: got %h required %h", i, log_char[s+i], ex[i]); end
        end
        finish_msg(to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got timeout required msg_done"); end
        wait_cycles(2);
    endtask

    task automatic test_back_to_back();
        logic [7:0] ex [8];
        int s, a, dc;
        bit to, pto;
        ex = '{8'hFF, 8'h61, 8'h62, 8'h00, 8'hFF, 8'h63, 8'h64, 8'h00};
        s = n_strobe;
        pto = 1'b0;
        push(8'h61, 1'b0, a, to); pto |= to;
        push(8'h62, 1'b1, a, to); pto |= to;
        push(8'h63, 1'b0, a, to); pto |= to;
        push(8'h64, 1'b1, a, to); pto |= to;
        wait_strobes(s + 4, 100, to);
        wait_cycles(3);
        n_checks++; if ((to | pto) !== 1'b0 || n_strobe !== s + 4) begin n_fail++; $display("FAIL b2b_hold: got %0d strobes required 4", n_strobe - s); end
        finish_msg(to);
        dc = done_cyc;
        wait_strobes(s + 8, 100, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout: got %0d strobes required 8", n_strobe - s); end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (log_char[s+i] !== ex[i]) begin n_fail++; $display("FAIL b2b_char%0d: got %h required %h", i, log_char[s+i], ex[i]); end
        end
        n_checks++; if (!(log_cyc[s+4] > dc)) begin n_fail++; $display("FAIL b2b_order: got start cycle %0d required > %0d", log_cyc[s+4], dc); end
        finish_msg(to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL b2b_done2: got timeout required msg_done"); end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_busy_pacing();
        test_fifo_full();
        test_drop();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
